// File: rtl/io_port_controller_if.sv
// CPU-side I/O bus for the switch/LED port: one-cycle request strobes,
// registered read data and a one-cycle ready pulse.
interface io_port_controller_if;
    logic       io_addr;
    logic       io_read;
    logic       io_write;
    logic [3:0] io_wdata;
    logic [3:0] io_rdata;
    logic       io_ready;

    modport master (
        output io_addr,
        output io_read,
        output io_write,
        output io_wdata,
        input  io_rdata,
        input  io_ready
    );

    modport slave (
        input  io_addr,
        input  io_read,
        input  io_write,
        input  io_wdata,
        output io_rdata,
        output io_ready
    );
endinterface

// File: rtl/io_port_controller.sv
// Board I/O port: synchronises and debounces the switches, keeps a sticky
// change flag and the LED register, and serves CPU reads/writes.
module io_port_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            switches,
    output logic [3:0]            LEDs,
    io_port_controller_if.slave   io
);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [3:0]           sync1_q, synced_q;
    logic [3:0]           cand_q, cand_d;
    logic [3:0]           stable_q, stable_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 change_flag_q, change_flag_d;
    logic [3:0]           leds_q, leds_d;
    logic [3:0]           rdata_q, rdata_d;
    state_e               state_q, state_d;
    logic                 flag_set, flag_clr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            synced_q      <= '0;
            cand_q        <= '0;
            stable_q      <= '0;
            cnt_q         <= '0;
            change_flag_q <= 1'b0;
            leds_q        <= '0;
            rdata_q       <= '0;
            state_q       <= StIdle;
        end else begin
            sync1_q       <= switches;
            synced_q      <= sync1_q;
            cand_q        <= cand_d;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            change_flag_q <= change_flag_d;
            leds_q        <= leds_d;
            rdata_q       <= rdata_d;
            state_q       <= state_d;
        end
    end

    // Debounce: a new synced value must hold for DEBOUNCE_CYCLES after loading.
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flag_set = 1'b0;
        if (synced_q != cand_q) begin
            cand_d = synced_q;
            cnt_d  = '0;
        end else if (cand_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = cand_q;
                flag_set = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Request FSM; read wins over a simultaneous write.
    always_comb begin
        state_d  = state_q;
        leds_d   = leds_q;
        rdata_d  = rdata_q;
        flag_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (io.io_read) begin
                    state_d  = StResp;
                    rdata_d  = io.io_addr ? {3'b000, change_flag_q} : stable_q;
                    flag_clr = io.io_addr;
                end else if (io.io_write) begin
                    state_d = StResp;
                    rdata_d = '0;
                    if (io.io_addr) begin
                        flag_clr = io.io_wdata[0];
                    end else begin
                        leds_d = io.io_wdata;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A debounce update in the same cycle as a clear keeps the flag set.
    always_comb begin
        change_flag_d = change_flag_q;
        if (flag_set) begin
            change_flag_d = 1'b1;
        end else if (flag_clr) begin
            change_flag_d = 1'b0;
        end
    end

    assign LEDs        = leds_q;
    assign io.io_rdata = rdata_q;
    assign io.io_ready = (state_q == StResp);

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Sequences all CPU access to the board I/O: the 4 switches (input) and the 4 LEDs (output).
- Sits between the processor's I/O bus and the top-level `switches`/`LEDs` pins of `system`.
- Synchronises and debounces the switches, keeps a sticky change flag, and holds the LED register.
- Serves CPU read/write requests through a one-cycle request/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a new synchronised switch value must stay constant before it is accepted (legal range 1..255).
- CNT_WIDTH, 8: width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- switches  input  4  raw board switches; asynchronous to clock.
- LEDs  output  4  registered LED drive.
- io_addr  input  1  register select: 0 = data (switch read / LED write), 1 = status.
- io_read  input  1  read request strobe.
- io_write  input  1  write request strobe.
- io_wdata  input  4  write data.
- io_rdata  output  4  read data; valid while io_ready=1.
- io_ready  output  1  one-cycle completion pulse for any accepted request.

Behaviour:
- Reset (reset=0, asynchronous) clears the following to 0:
  - outputs: LEDs, io_rdata, io_ready;
  - internal: sync flops, candidate, stable, debounce counter, change_flag;
  - FSM goes to IDLE.
- Synchroniser: switches pass through 2 flops → `synced`. The raw input is used nowhere else.
- Debounce:
  - If synced ≠ candidate: candidate ← synced, counter ← 0.
  - Else if candidate ≠ stable: counter increments; when counter = DEBOUNCE_CYCLES-1, stable ← candidate, change_flag ← 1, counter ← 0.
  - Else counter holds 0.
  - Minimum latency from a pin edge to a stable update is 2 + DEBOUNCE_CYCLES + 1 cycles (2 sync, 1 candidate load, DEBOUNCE_CYCLES count).
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches stable.
  - With DEBOUNCE_CYCLES=1, the value is accepted one cycle after candidate loads.
- FSM, 2 states:
  - IDLE: samples io_read/io_write each cycle.
    - io_read=1 → capture read data, go to RESP. Read wins if io_write is also 1; the write is dropped and LEDs are unchanged.
    - io_write=1 (read=0) → perform the write, go to RESP.
  - RESP: io_ready=1 for exactly this cycle; io_rdata holds the captured value. Requests arriving in RESP are ignored, not queued. Always returns to IDLE. Back-to-back requests are therefore serviced at most every 2 cycles.
- Read data, registered at the IDLE→RESP edge:
  - addr 0 → stable.
  - addr 1 → {3'b000, change_flag}.
  - A status read clears change_flag at the same edge. If a debounce update sets the flag in that same cycle, the set wins: the flag reads as the old value and ends at 1.
- Writes:
  - addr 0 → LEDs ← io_wdata at the IDLE→RESP edge.
  - addr 1 → writing 1 in bit0 clears change_flag (set still wins on collision). Other bits are ignored.
- io_rdata holds its last value outside RESP. It is 0 after write responses.
- Reset asserted mid-transaction aborts it. io_ready drops immediately and no write takes effect unless its edge already occurred.

Test Plan:
- Reset release, switches=4'b0000, no requests → LEDs=0, io_ready=0, io_rdata=0; status read returns 4'b0000.
- switches 0000→0101 held, DEBOUNCE_CYCLES=4 → stable=0101 exactly 7 cycles after the first clock edge seeing 0101; a data read returns io_rdata=4'b0101 with io_ready=1 one cycle after the strobe; the following status read returns 4'b0001, and a second status read returns 4'b0000.
- switches pulse 0000→1111→0000 lasting 3 cycles → stable stays 0000; status read returns 4'b0000.
- Write addr0 io_wdata=4'b1010 → LEDs=1010 one cycle after the strobe, io_ready pulses once; a write with io_read also high leaves LEDs=1010 and returns read data.
- io_read held high 4 cycles on addr0 → io_ready high on cycles 2 and 4 only (alternating), never 2 consecutive cycles.
- Status read issued in the same cycle the debounce accepts a new value → returned bit0=0 (old flag), change_flag=1 afterwards; a further status read returns 4'b0001.
- Assert reset during RESP after writing LEDs=0011 → LEDs, io_ready, change_flag drop to 0 asynchronously before the next clock edge.
